// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, shifts
// 8 data bits + odd parity + stop on device clock falling edges, then checks the ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 180000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_drive_low,
  output logic       ps2data_drive_low
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t INHIBIT_LAST = cnt_t'(INHIBIT_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t     r_state;
  cnt_t       r_cnt;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_busy;
  logic       r_done;
  logic       r_error;
  logic       r_clk_low;
  logic       r_data_low;

  logic       r_clk_meta;
  logic       r_clk_sync;
  logic       r_clk_prev;
  logic       r_data_meta;
  logic       r_data_sync;

  logic       w_fall;
  logic       w_timeout;
  cnt_t       w_cnt_inc;

  assign w_fall    = r_clk_prev & ~r_clk_sync;
  // The counter is one behind the elapsed cycle count, so this fires exactly
  // TIMEOUT_CYCLES cycles after the last clear.
  assign w_timeout = (r_cnt >= TIMEOUT_LAST);
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + cnt_t'(1);

  assign busy              = r_busy;
  assign done              = r_done;
  assign error             = r_error;
  assign ps2clk_drive_low  = r_clk_low;
  assign ps2data_drive_low = r_data_low;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_clk_low   <= 1'b0;
      r_data_low  <= 1'b0;
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2clk_in;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2data_in;
      r_data_sync <= r_data_meta;
      r_done      <= 1'b0;
      r_error     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_busy     <= 1'b0;
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          if (tx_start) begin
            r_shift   <= tx_data;
            r_parity  <= ~^tx_data;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_clk_low <= 1'b1;
            r_state   <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (r_cnt >= INHIBIT_LAST) begin
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_RTS;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_RTS: begin
          r_bit_cnt <= '0;
          if (w_timeout) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt   <= w_fall ? '0 : w_cnt_inc;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_fall) begin
            r_cnt     <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt < 4'd8) begin
              r_data_low <= ~r_shift[0];
              r_shift    <= r_shift >> 1;
            end else if (r_bit_cnt == 4'd8) begin
              r_data_low <= ~r_parity;
            end else begin
              // Stop bit: release data and wait for the device to answer.
              r_data_low <= 1'b0;
              r_state    <= S_ACK;
            end
          end else if (w_timeout) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_ACK: begin
          if (w_fall) begin
            r_cnt <= '0;
            if (!r_data_sync) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        S_WAIT_IDLE: begin
          if (r_clk_sync && r_data_sync) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_error    <= 1'b1;
            r_busy     <= 1'b0;
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= w_fall ? '0 : w_cnt_inc;
          end
        end

        default: begin
          r_busy     <= 1'b0;
          r_clk_low  <= 1'b0;
          r_data_low <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-collector bus with a behavioural PS/2 device that
// clocks frames in, compared against frames built from the byte with plain arithmetic.
module tb_ps2_host_tx;

  localparam int INH = 1200;
  localparam int TO  = 3000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       busy, done, error;
  logic       clk_dl, data_dl;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2clk_line, ps2data_line;

  assign ps2clk_line  = ~(clk_dl | dev_clk_low);
  assign ps2data_line = ~(data_dl | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done), .error(error),
    .ps2clk_in(ps2clk_line), .ps2data_in(ps2data_line),
    .ps2clk_drive_low(clk_dl), .ps2data_drive_low(data_dl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: pulse counts, inhibit length, RTS/error timestamps, rule violations.
  int   n_done = 0, n_err = 0, n_viol = 0, n_bfall = 0, n_bfall_pulse = 0;
  int   inh_run = 0, inh_len = 0, rts_cyc = 0, err_cyc = 0;
  logic err_busy = 1'b0, prev_busy = 1'b0, prev_cl = 1'b0, prev_dl = 1'b0;

  always @(negedge clk) begin
    if (done) n_done <= n_done + 1;
    if (error) begin
      n_err    <= n_err + 1;
      err_cyc  <= cyc;
      err_busy <= busy;
    end
    if ((done && error) || ((done || error) && (clk_dl || data_dl)) || (done && busy))
      n_viol <= n_viol + 1;
    if (prev_busy && !busy) begin
      n_bfall <= n_bfall + 1;
      if (done || error) n_bfall_pulse <= n_bfall_pulse + 1;
    end
    if (clk_dl) inh_run <= inh_run + 1;
    else if (prev_cl) begin
      inh_len <= inh_run;
      inh_run <= 0;
    end
    if (data_dl && !prev_dl) rts_cyc <= cyc;
    prev_busy <= busy;
    prev_cl   <= clk_dl;
    prev_dl   <= data_dl;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame as the device should see it: {stop=1, odd parity, data[7:0]}.
  function automatic logic [9:0] frame_of(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d};
  endfunction

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Device side: wait for request-to-send, then generate 11 clocks sampling the
  // host's bit while clock is low; optionally ACK in the 11th slot or stop early.
  task automatic device_xfer(input int half, input bit ack, input int abort_fall,
                             output logic [9:0] bits, output int fall11);
    int w;
    bits   = '0;
    fall11 = 0;
    w = 0;
    while (!(clk_dl == 1'b0 && data_dl == 1'b1) && w < 5000) begin
      tick(1);
      w++;
    end
    check("rts_seen", 32'(w < 5000), 32'd1);
    if (w >= 5000) return;
    tick(4);
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        tick(half / 2);
      end
      dev_clk_low = 1'b1;
      if (k == 11) fall11 = cyc;
      if (k == abort_fall) return;
      tick(half);
      if (k <= 10) bits[k-1] = ps2data_line;
      dev_clk_low = 1'b0;
      tick(half);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_xfer(input string tag, input logic [7:0] d, input int half,
                          input bit ack, input bit dup_start);
    logic [9:0] bits;
    int f11, d0, e0, v0, b0, bp0;
    d0 = n_done; e0 = n_err; v0 = n_viol; b0 = n_bfall; bp0 = n_bfall_pulse;
    start_tx(d);
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    fork
      device_xfer(half, ack, 0, bits, f11);
      begin
        if (dup_start) begin
          tick(INH + 3 * half);
          tx_data  = 8'h00;
          tx_start = 1'b1;
          tick(1);
          tx_start = 1'b0;
        end
      end
    join
    tick(30);
    $display("xfer %s: data=%02h half=%0d ack=%0d frame=%03h done=%0d err=%0d",
             tag, d, half, ack, bits, n_done - d0, n_err - e0);
    check({tag, "_frame"}, 32'(bits), 32'(frame_of(d)));
    check({tag, "_inhibit"}, 32'(inh_len), 32'(INH));
    check({tag, "_done"}, 32'(n_done - d0), 32'(ack));
    check({tag, "_error"}, 32'(n_err - e0), 32'(!ack));
    check({tag, "_viol"}, 32'(n_viol - v0), 32'd0);
    check({tag, "_busy_fall"}, 32'(n_bfall - b0), 32'd1);
    check({tag, "_busy_with_pulse"}, 32'(n_bfall_pulse - bp0), 32'd1);
    if (!ack) check({tag, "_nack_latency"}, 32'(err_cyc - f11), 32'd3);
    check({tag, "_idle_outs"}, 32'({busy, clk_dl, data_dl}), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got cycle %0d, want finish before it", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    int f11, d0, e0, v0;

    // Reset, with a concurrent start request that must be ignored.
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    tick(4);
    rst      = 1'b0;
    tx_start = 1'b0;
    check("reset_outs", 32'({busy, done, error, clk_dl, data_dl}), 32'd0);
    tick(5);
    check("start_during_reset", 32'({busy, clk_dl}), 32'd0);
    $display("xfer reset: outputs=%05b", {busy, done, error, clk_dl, data_dl});

    run_xfer("ed_12k5", 8'hED, 480, 1'b1, 1'b0);
    run_xfer("f4", 8'hF4, 100, 1'b1, 1'b0);
    run_xfer("nack", 8'h3C, 100, 1'b0, 1'b0);

    // Device never clocks: error exactly TO cycles after request-to-send.
    d0 = n_done; e0 = n_err; v0 = n_viol;
    start_tx(8'h5A);
    tick(INH + TO + 50);
    $display("xfer timeout: rts@%0d err@%0d", rts_cyc, err_cyc);
    check("to_error", 32'(n_err - e0), 32'd1);
    check("to_done", 32'(n_done - d0), 32'd0);
    check("to_latency", 32'(err_cyc - rts_cyc), 32'(TO));
    check("to_busy_at_err", 32'(err_busy), 32'd0);
    check("to_viol", 32'(n_viol - v0), 32'd0);
    check("to_idle_outs", 32'({busy, clk_dl, data_dl}), 32'd0);

    // Reset at the 5th falling edge aborts silently.
    d0 = n_done; e0 = n_err;
    start_tx(8'hED);
    device_xfer(100, 1'b1, 5, bits, f11);
    rst = 1'b1;
    tick(1);
    check("rst_mid_outs", 32'({busy, done, error, clk_dl, data_dl}), 32'd0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    tick(50);
    $display("xfer abort: done=%0d err=%0d", n_done - d0, n_err - e0);
    check("rst_mid_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
    run_xfer("ed_after_rst", 8'hED, 100, 1'b1, 1'b0);

    run_xfer("ed_dup_start", 8'hED, 100, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("rnd%0d", i), 8'($urandom_range(0, 255)),
               int'($urandom_range(20, 60)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
